alu_seq_ctrl: RTL

- Sequencer that owns one instance of the team's 16-bit Hack ALU (`alu`: x, y, zx, nx, zy, ny, f, no → out, zr, ng) and drives its control bits over multiple cycles.
- Provides two operations behind a start/done handshake:
  - a single direct ALU operation;
  - a 16x16 shift-add multiply (low 16 bits of the product) built only from ALU additions.
- Sits between the CPU control path and the ALU, so a multiply becomes a multi-cycle instruction.

---
 rtl/alu_seq_ctrl_if.sv | 24 ++
 rtl/alu_seq_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl_if.sv
// CPU-side request/response bundle for the ALU sequencer: start/op/operands in,
// busy/done/result/flags out. Master = requester, slave = sequencer.
interface alu_seq_ctrl_if;
    logic        start;
    logic        op;
    logic [5:0]  ctrl;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        zr;
    logic        ng;

    modport master (
        output start, op, ctrl, a, b,
        input  busy, done, result, zr, ng
    );

    modport slave (
        input  start, op, ctrl, a, b,
        output busy, done, result, zr, ng
    );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Hack ALU sequencer: direct op (done in cycle 2) or shift-add multiply (cycle 2..34).
// No backpressure: start is taken only in IDLE/DONE, ignored while busy.
module alu (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        zx,
    input  logic        nx,
    input  logic        zy,
    input  logic        ny,
    input  logic        f,
    input  logic        no,
    output logic [15:0] out,
    output logic        zr,
    output logic        ng
);
    logic [15:0] x1, y1, o1;

    always_comb begin
        x1  = zx ? 16'h0000 : x;
        x1  = nx ? ~x1 : x1;
        y1  = zy ? 16'h0000 : y;
        y1  = ny ? ~y1 : y1;
        o1  = f ? (x1 + y1) : (x1 & y1);
        out = no ? ~o1 : o1;
        zr  = (out == 16'h0000);
        ng  = out[15];
    end
endmodule

module alu_seq_ctrl #(
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    alu_seq_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, EXEC, ADD, SHIFT, DONE} state_t;

    localparam logic [5:0] CTRL_ADD = 6'b000010;

    state_t      state, state_nxt;
    logic [15:0] acc, mcand, mplier;
    logic [4:0]  iter;
    logic [5:0]  ctrl_l;
    logic [15:0] res_q;
    logic        zr_q, ng_q;

    logic [15:0] alu_x, alu_y, alu_out;
    logic [5:0]  alu_ctrl;
    logic        alu_zr, alu_ng;
    logic        mul_exit;

    assign mul_exit = ((EARLY_EXIT != 1'b0) && (mplier == 16'h0000)) || (iter == 5'd16);

    alu u_alu (
        .x   (alu_x),
        .y   (alu_y),
        .zx  (alu_ctrl[5]),
        .nx  (alu_ctrl[4]),
        .zy  (alu_ctrl[3]),
        .ny  (alu_ctrl[2]),
        .f   (alu_ctrl[1]),
        .no  (alu_ctrl[0]),
        .out (alu_out),
        .zr  (alu_zr),
        .ng  (alu_ng)
    );

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (bus.start) state_nxt = bus.op ? ADD : EXEC;
                else           state_nxt = IDLE;
            end
            EXEC:    state_nxt = DONE;
            ADD:     state_nxt = mul_exit ? DONE : SHIFT;
            SHIFT:   state_nxt = ADD;
            default: state_nxt = IDLE;
        endcase
    end

    // Direct ops reuse mcand/mplier as the latched x/y operands.
    always_comb begin
        alu_x    = 16'h0000;
        alu_y    = 16'h0000;
        alu_ctrl = 6'b000000;
        case (state)
            EXEC: begin
                alu_x    = mcand;
                alu_y    = mplier;
                alu_ctrl = ctrl_l;
            end
            ADD: begin
                alu_x    = acc;
                alu_y    = mcand;
                alu_ctrl = CTRL_ADD;
            end
            SHIFT: begin
                alu_x    = mcand;
                alu_y    = mcand;
                alu_ctrl = CTRL_ADD;
            end
            default: ;
        endcase
    end

    assign bus.busy   = (state == EXEC) || (state == ADD) || (state == SHIFT);
    assign bus.done   = (state == DONE);
    assign bus.result = res_q;
    assign bus.zr     = zr_q;
    assign bus.ng     = ng_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            acc    <= 16'h0000;
            mcand  <= 16'h0000;
            mplier <= 16'h0000;
            iter   <= 5'd0;
            ctrl_l <= 6'b000000;
            res_q  <= 16'h0000;
            zr_q   <= 1'b0;
            ng_q   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        ctrl_l <= bus.ctrl;
                        mcand  <= bus.a;
                        mplier <= bus.b;
                        acc    <= 16'h0000;
                        iter   <= 5'd0;
                    end
                end
                EXEC: begin
                    res_q <= alu_out;
                    zr_q  <= alu_zr;
                    ng_q  <= alu_ng;
                end
                ADD: begin
                    if (mul_exit) begin
                        res_q <= acc;
                        zr_q  <= (acc == 16'h0000);
                        ng_q  <= acc[15];
                    end else if (mplier[0]) begin
                        acc <= alu_out;
                    end
                end
                SHIFT: begin
                    mcand  <= alu_out;
                    mplier <= {1'b0, mplier[15:1]};
                    iter   <= iter + 5'd1;
                end
                default: ;
            endcase
        end
    end
endmodule
